// File: rtl/ram_dma_pkg.sv
// Shared definitions for the ram_dma block: FSM encoding, mode encodings, default widths.
// Overlap-safe copy is enabled by defining RAM_DMA_MEMMOVE_EN.
package ram_dma_pkg;

   localparam int DEF_ADDR_W = 19;
   localparam int DEF_LEN_W  = 16;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_HOLD = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RD) || (s == ST_HOLD) || (s == ST_WR);
   endfunction

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Source/destination address counters for ram_dma: load, up/down stepping, modulo-2^ADDR_W wrap.
// Descending mode is chosen at load time when allow_down is set and the regions overlap forward.
module ram_dma_addr_gen
   import ram_dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              allow_down,
   input  logic [ADDR_W-1:0] src_in,
   input  logic [ADDR_W-1:0] dst_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic              step,
   output logic [ADDR_W-1:0] src_cur,
   output logic [ADDR_W-1:0] dst_cur
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] len_ext;
   logic [ADDR_W-1:0] len_m1;
   logic [ADDR_W:0]   src_end;
   logic              overlap;
   logic              go_down;
   logic              down_q;

   if (LEN_W >= ADDR_W) begin : g_len_trunc
      assign len_ext = len_in[ADDR_W-1:0];
   end else begin : g_len_ext
      assign len_ext = {{(ADDR_W-LEN_W){1'b0}}, len_in};
   end

   assign len_m1  = len_ext - ADDR_ONE;
   assign src_end = {1'b0, src_in} + {1'b0, len_ext};

   // Forward overlap (src < dst < src+len) would clobber unread source bytes when walking upward.
   assign overlap = (src_in < dst_in) && ({1'b0, dst_in} < src_end);
   assign go_down = allow_down && overlap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_cur <= '0;
         dst_cur <= '0;
         down_q  <= 1'b0;
      end else if (load) begin
         down_q  <= go_down;
         src_cur <= go_down ? (src_in + len_m1) : src_in;
         dst_cur <= go_down ? (dst_in + len_m1) : dst_in;
      end else if (step) begin
         src_cur <= down_q ? (src_cur - ADDR_ONE) : (src_cur + ADDR_ONE);
         dst_cur <= down_q ? (dst_cur - ADDR_ONE) : (dst_cur + ADDR_ONE);
      end
   end

endmodule

// File: rtl/ram_dma.sv
// ram_dma: byte-wide copy/fill engine driving a single-port RAM (read data one cycle after the read strobe).
// Define RAM_DMA_MEMMOVE_EN for overlap-safe (descending) copies.
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [7:0]        fill_byte,
   output logic              busy,
   output logic              done,
   output logic              ram_cs,
   output logic              ram_rw,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output state_t            dbg_state
);

   // Handshake: start is a one-cycle request taken only in IDLE (busy=0, done=0); the request
   // parameters are latched on that edge, busy covers RD/HOLD/WR, and done pulses for one cycle
   // after the final write, after which the engine is back in IDLE.

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t            state_q;
   state_t            state_d;
   logic              accept;
   logic              allow_down;
   logic              mode_q;
   logic [7:0]        fill_q;
   logic [7:0]        hold_q;
   logic [LEN_W-1:0]  remain_q;
   logic [ADDR_W-1:0] src_cur;
   logic [ADDR_W-1:0] dst_cur;

   assign accept    = (state_q == ST_IDLE) && start;
   assign dbg_state = state_q;

`ifdef RAM_DMA_MEMMOVE_EN
   assign allow_down = (mode == MODE_COPY);
`else
   assign allow_down = 1'b0;
`endif

   ram_dma_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .allow_down (allow_down),
      .src_in     (src_addr),
      .dst_in     (dst_addr),
      .len_in     (length),
      .step       (state_q == ST_WR),
      .src_cur    (src_cur),
      .dst_cur    (dst_cur)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_d = ST_DONE;
               end else if (mode == MODE_FILL) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD:   state_d = ST_HOLD;
         ST_HOLD: state_d = ST_WR;
         ST_WR: begin
            if (remain_q == LEN_ONE) begin
               state_d = ST_DONE;
            end else if (mode_q == MODE_COPY) begin
               state_d = ST_RD;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q   <= MODE_COPY;
         fill_q   <= '0;
         remain_q <= '0;
         hold_q   <= '0;
      end else begin
         if (accept) begin
            mode_q   <= mode;
            fill_q   <= fill_byte;
            remain_q <= length;
         end else if (state_q == ST_WR) begin
            remain_q <= remain_q - LEN_ONE;
         end
         if (state_q == ST_HOLD) begin
            hold_q <= ram_rdata;
         end
      end
   end

   always_comb begin
      busy      = is_busy(state_q);
      done      = 1'b0;
      ram_cs    = 1'b0;
      ram_rw    = 1'b1;
      ram_read  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state_q)
         ST_RD: begin
            ram_cs   = 1'b1;
            ram_read = 1'b1;
            ram_addr = src_cur;
         end
         ST_WR: begin
            ram_cs    = 1'b1;
            ram_rw    = 1'b0;
            ram_addr  = dst_cur;
            ram_wdata = (mode_q == MODE_FILL) ? fill_q : hold_q;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: RAM model, write scoreboard, one task per scenario.
// Expectations for the overlap copy follow RAM_DMA_MEMMOVE_EN.
module tb_ram_dma;
   import ram_dma_pkg::*;

   localparam int ADDR_W   = 19;
   localparam int LEN_W    = 16;
   localparam int MEM_SIZE = 1 << ADDR_W;
   localparam int W        = ADDR_W + 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  length;
   logic [7:0]        fill_byte;
   logic              busy;
   logic              done;
   logic              ram_cs;
   logic              ram_rw;
   logic              ram_read;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;
   logic [2:0]        dbg_state;

   bit [7:0]          mem [0:MEM_SIZE-1];
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [7:0]        pre_data;

   logic [W-1:0]      exp_q[$];
   int                checks;
   int                errors;
   int                cs_cnt;

   ram_dma #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .length    (length),
      .fill_byte (fill_byte),
      .busy      (busy),
      .done      (done),
      .ram_cs    (ram_cs),
      .ram_rw    (ram_rw),
      .ram_read  (ram_read),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write on cs & !rw, read data registered (valid the next cycle)
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (ram_cs && !ram_rw) mem[ram_addr] <= ram_wdata;
      if (ram_cs && ram_read) ram_rdata <= mem[ram_addr];
   end

   // scoreboard and bus-idle monitor
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (ram_cs) cs_cnt++;
      if (ram_cs && !ram_rw) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%05h data=%02h, no write expected", ram_addr, ram_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({ram_addr, ram_wdata} !== e) begin
               errors++;
               $display("FAIL write: addr=%05h data=%02h, expected addr=%05h data=%02h",
                        ram_addr, ram_wdata, e[W-1:8], e[7:0]);
            end
         end
      end
      if (!ram_cs) begin
         checks++;
         if (ram_read !== 1'b0 || ram_rw !== 1'b1 || ram_addr !== '0 || ram_wdata !== 8'h00) begin
            errors++;
            $display("FAIL bus_idle: read=%b rw=%b addr=%05h wdata=%02h, expected 0/1/0/0",
                     ram_read, ram_rw, ram_addr, ram_wdata);
         end
      end
      if (done && busy) begin
         errors++;
         $display("FAIL done_busy: busy=1 during done, expected 0");
      end
   end

   // driver tasks
   task automatic mem_poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic start_xfer(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [LEN_W-1:0] n, input logic [7:0] f);
      mode      = m;
      src_addr  = s;
      dst_addr  = d;
      length    = n;
      fill_byte = f;
      start     = 1'b1;
   endtask

   task automatic wait_done(output int lat, output int busy_n, output bit to);
      lat    = 0;
      busy_n = 0;
      to     = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) busy_n++;
         if (done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   // scenario tasks
   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ram_cs !== 1'b0 || ram_read !== 1'b0 || ram_rw !== 1'b1 ||
          ram_addr !== '0 || ram_wdata !== 8'h00 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b cs=%b read=%b rw=%b addr=%05h wdata=%02h st=%0d, expected 0 0 0 0 1 0 0 IDLE",
                  busy, done, ram_cs, ram_read, ram_rw, ram_addr, ram_wdata, dbg_state);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: st=%0d busy=%b, expected IDLE 0", dbg_state, busy);
      end
   endtask

   task automatic check_xfer(input string name, input int lat, input int busy_n, input bit to,
                             input int exp_lat, input int exp_busy);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s_timeout: no done within 200 cycles", name);
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s_latency: done after %0d cycles, expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (busy_n !== exp_busy) begin
         errors++;
         $display("FAIL %s_busy: busy high %0d cycles, expected %0d", name, busy_n, exp_busy);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_pending: %0d writes missing, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_fill();
      int lat, busy_n;
      bit to;
      for (int i = 0; i < 4; i++) push_exp(19'h01000 + 19'(i), 8'hA5);
      start_xfer(MODE_FILL, 19'h0, 19'h01000, 16'd4, 8'hA5);
      wait_done(lat, busy_n, to);
      check_xfer("fill", lat, busy_n, to, 5, 4);
   endtask

   task automatic test_copy();
      int lat, busy_n;
      bit to;
      mem_poke(19'h10000, 8'h11);
      mem_poke(19'h10001, 8'h22);
      mem_poke(19'h10002, 8'h33);
      push_exp(19'h02000, 8'h11);
      push_exp(19'h02001, 8'h22);
      push_exp(19'h02002, 8'h33);
      start_xfer(MODE_COPY, 19'h10000, 19'h02000, 16'd3, 8'h00);
      wait_done(lat, busy_n, to);
      check_xfer("copy", lat, busy_n, to, 10, 9);
      @(negedge clk);
      checks++;
      if (mem[19'h02000] !== 8'h11 || mem[19'h02001] !== 8'h22 || mem[19'h02002] !== 8'h33) begin
         errors++;
         $display("FAIL copy_mem: %02h %02h %02h, expected 11 22 33",
                  mem[19'h02000], mem[19'h02001], mem[19'h02002]);
      end
   endtask

   task automatic test_zero_len();
      int lat, busy_n, cs0;
      bit to;
      cs0 = cs_cnt;
      start_xfer(MODE_FILL, 19'h0, 19'h03000, 16'd0, 8'hEE);
      wait_done(lat, busy_n, to);
      check_xfer("zero_len", lat, busy_n, to, 1, 0);
      checks++;
      if (cs_cnt !== cs0) begin
         errors++;
         $display("FAIL zero_len_cs: %0d ram_cs cycles, expected 0", cs_cnt - cs0);
      end
   endtask

   task automatic test_wrap();
      int lat, busy_n;
      bit to;
      push_exp(19'h7FFFE, 8'h5A);
      push_exp(19'h7FFFF, 8'h5A);
      push_exp(19'h00000, 8'h5A);
      start_xfer(MODE_FILL, 19'h0, 19'h7FFFE, 16'd3, 8'h5A);
      wait_done(lat, busy_n, to);
      check_xfer("wrap", lat, busy_n, to, 4, 3);
   endtask

   task automatic test_start_ignored();
      int lat, busy_n;
      bit to;
      for (int i = 0; i < 3; i++) push_exp(19'h04000 + 19'(i), 8'h3C);
      start_xfer(MODE_FILL, 19'h0, 19'h04000, 16'd3, 8'h3C);
      @(negedge clk);
      start_xfer(MODE_COPY, 19'h12345, 19'h05000, 16'd9, 8'hFF);
      wait_done(lat, busy_n, to);
      check_xfer("start_ignored", lat + 1, busy_n + 1, to, 4, 3);
   endtask

   task automatic test_back_to_back();
      int lat, busy_n;
      bit to;
      push_exp(19'h06000, 8'h77);
      push_exp(19'h06001, 8'h77);
      start_xfer(MODE_FILL, 19'h0, 19'h06000, 16'd2, 8'h77);
      wait_done(lat, busy_n, to);
      check_xfer("b2b_first", lat, busy_n, to, 3, 2);
      @(negedge clk);
      push_exp(19'h07000, 8'h77);
      push_exp(19'h07001, 8'h77);
      start_xfer(MODE_COPY, 19'h06000, 19'h07000, 16'd2, 8'h00);
      wait_done(lat, busy_n, to);
      check_xfer("b2b_second", lat, busy_n, to, 7, 6);
   endtask

   task automatic test_random_fill();
      int lat, busy_n, n;
      bit to;
      logic [ADDR_W-1:0] d;
      logic [7:0] f;
      for (int k = 0; k < 4; k++) begin
         d = 19'($urandom_range(0, MEM_SIZE - 1));
         n = $urandom_range(1, 6);
         f = 8'($urandom_range(0, 255));
         for (int i = 0; i < n; i++) push_exp(d + 19'(i), f);
         start_xfer(MODE_FILL, 19'h0, d, 16'(n), f);
         wait_done(lat, busy_n, to);
         check_xfer("random_fill", lat, busy_n, to, n + 1, n);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      int cs0;
      mem_poke(19'h20000, 8'hAA);
      mem_poke(19'h20001, 8'hBB);
      mem_poke(19'h20002, 8'hCC);
      mem_poke(19'h20003, 8'hDD);
      push_exp(19'h08000, 8'hAA);
      start_xfer(MODE_COPY, 19'h20000, 19'h08000, 16'd4, 8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (dbg_state !== ST_HOLD) begin
         errors++;
         $display("FAIL reset_mid_state: st=%0d before reset, expected HOLD", dbg_state);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ram_cs !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_mid_async: cs=%b busy=%b st=%0d, expected 0 0 IDLE", ram_cs, busy, dbg_state);
      end
      cs0 = cs_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (dbg_state !== ST_IDLE || cs_cnt !== cs0) begin
         errors++;
         $display("FAIL reset_mid_idle: st=%0d extra_cs=%0d, expected IDLE 0", dbg_state, cs_cnt - cs0);
      end
      checks++;
      if (mem[19'h08000] !== 8'hAA || mem[19'h08001] !== 8'h00 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_mid_mem: %02h %02h pending=%0d, expected AA 00 0",
                  mem[19'h08000], mem[19'h08001], exp_q.size());
      end
   endtask

   task automatic test_memmove();
      int lat, busy_n;
      bit to;
      logic [31:0] exp_word;
      for (int i = 0; i < 4; i++) mem_poke(19'h100 + 19'(i), 8'(i + 1));
`ifdef RAM_DMA_MEMMOVE_EN
      push_exp(19'h105, 8'h04);
      push_exp(19'h104, 8'h03);
      push_exp(19'h103, 8'h02);
      push_exp(19'h102, 8'h01);
      exp_word = 32'h01020304;
`else
      push_exp(19'h102, 8'h01);
      push_exp(19'h103, 8'h02);
      push_exp(19'h104, 8'h01);
      push_exp(19'h105, 8'h02);
      exp_word = 32'h01020102;
`endif
      start_xfer(MODE_COPY, 19'h100, 19'h102, 16'd4, 8'h00);
      wait_done(lat, busy_n, to);
      check_xfer("memmove", lat, busy_n, to, 13, 12);
      @(negedge clk);
      checks++;
      if ({mem[19'h102], mem[19'h103], mem[19'h104], mem[19'h105]} !== exp_word) begin
         errors++;
         $display("FAIL memmove_mem: %02h %02h %02h %02h, expected %08h",
                  mem[19'h102], mem[19'h103], mem[19'h104], mem[19'h105], exp_word);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cs_cnt    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      mode      = MODE_COPY;
      src_addr  = '0;
      dst_addr  = '0;
      length    = '0;
      fill_byte = '0;
      pre_we    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      @(negedge clk);
      test_reset();
      test_fill();
      @(negedge clk);
      test_copy();
      test_zero_len();
      @(negedge clk);
      test_wrap();
      @(negedge clk);
      test_start_ignored();
      @(negedge clk);
      test_back_to_back();
      @(negedge clk);
      test_random_fill();
      test_reset_mid();
      test_memmove();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
